// File: rtl/cache_manage_unit_if.sv
// Memory-side bus between the cache controller (master) and main memory (slave).
interface cache_manage_unit_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32
);

  logic                 mem_cs_o;
  logic                 mem_we_o;
  logic [ADDR_BITS-1:0] mem_addr_o;
  logic [DATA_BITS-1:0] mem_data_o;
  logic [DATA_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport master (
    output mem_cs_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_data_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_cs_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_data_i,
    output mem_ack_i
  );

endinterface

// File: rtl/cache_manage_unit.sv
// Cache controller: sequences lookup, dirty-victim write-back and line refill
// for a 2-way set-associative array, and stalls the CPU until the access hits.
module cache_manage_unit #(
  parameter int unsigned ADDR_BITS           = 32,
  parameter int unsigned TAG_BITS            = 23,
  parameter int unsigned SET_INDEX_WIDTH     = 5,
  parameter int unsigned ELEMENT_WORDS_WIDTH = 2,
  parameter int unsigned WORD_BYTES_WIDTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,

  // CPU memory stage
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [2:0]           u_b_h_w,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,

  // cache array
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_edit,
  output logic                 cache_store,
  output logic                 cache_invalid,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic [31:0]          cache_dout,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,

  // main memory
  cache_manage_unit_if.master  mem
);

  localparam int unsigned INDEX_LSB = ELEMENT_WORDS_WIDTH + WORD_BYTES_WIDTH;
  localparam int unsigned TAG_LSB   = INDEX_LSB + SET_INDEX_WIDTH;

  // Line transfers always move whole words.
  localparam logic [2:0] WIDTH_WORD = 3'b010;
  localparam logic [ELEMENT_WORDS_WIDTH-1:0] LAST_WORD = '1;
  localparam logic [ELEMENT_WORDS_WIDTH-1:0] WORD_ONE  = ELEMENT_WORDS_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_PRE_BACK = 3'd2,
    S_BACK     = 3'd3,
    S_FILL     = 3'd4,
    S_WAIT     = 3'd5
  } state_t;

  state_t                         state;
  state_t                         state_nx;
  logic [ELEMENT_WORDS_WIDTH-1:0] word;
  logic [ELEMENT_WORDS_WIDTH-1:0] word_nx;
  logic [TAG_BITS-1:0]            vic_tag;
  logic [TAG_BITS-1:0]            vic_tag_nx;

  logic                           req_c;
  logic [SET_INDEX_WIDTH-1:0]     req_index;
  logic [TAG_BITS-1:0]            req_tag;
  logic [ADDR_BITS-1:0]           back_addr;
  logic [ADDR_BITS-1:0]           fill_addr;

  logic                           mem_cs_c;
  logic                           mem_we_c;
  logic [ADDR_BITS-1:0]           mem_addr_c;
  logic [31:0]                    mem_data_c;

  // Request decode and line-transfer word addresses
  assign req_c     = en_r | en_w;
  assign req_index = addr_rw[INDEX_LSB +: SET_INDEX_WIDTH];
  assign req_tag   = addr_rw[TAG_LSB +: TAG_BITS];
  assign back_addr = ADDR_BITS'({vic_tag, req_index, word, {WORD_BYTES_WIDTH{1'b0}}});
  assign fill_addr = ADDR_BITS'({req_tag, req_index, word, {WORD_BYTES_WIDTH{1'b0}}});

  // Invalidation is never requested by this controller.
  assign cache_invalid = 1'b0;

  assign mem.mem_cs_o   = mem_cs_c;
  assign mem.mem_we_o   = mem_we_c;
  assign mem.mem_addr_o = mem_addr_c;
  assign mem.mem_data_o = mem_data_c;

  // State register, line word counter and latched victim tag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      word    <= '0;
      vic_tag <= '0;
    end else begin
      state   <= state_nx;
      word    <= word_nx;
      vic_tag <= vic_tag_nx;
    end
  end

  // Next-state: lookup, optional write-back of 4 words, refill of 4 words, replay
  always_comb begin
    state_nx   = state;
    word_nx    = word;
    vic_tag_nx = vic_tag;
    unique case (state)
      S_IDLE: begin
        if (req_c) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          state_nx = S_IDLE;
        end else begin
          vic_tag_nx = cache_tag;
          word_nx    = '0;
          state_nx   = (cache_valid && cache_dirty) ? S_PRE_BACK : S_FILL;
        end
      end
      S_PRE_BACK: begin
        state_nx = S_BACK;
      end
      S_BACK: begin
        if (mem.mem_ack_i) begin
          if (word == LAST_WORD) begin
            word_nx  = '0;
            state_nx = S_FILL;
          end else begin
            word_nx  = word + WORD_ONE;
            state_nx = S_PRE_BACK;
          end
        end
      end
      S_FILL: begin
        if (mem.mem_ack_i) begin
          if (word == LAST_WORD) begin
            state_nx = S_WAIT;
          end else begin
            word_nx = word + WORD_ONE;
          end
        end
      end
      S_WAIT: begin
        state_nx = S_LOOKUP;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs: array strobes, memory bus and CPU stall; everything low in reset
  always_comb begin
    data_r        = '0;
    stall         = 1'b0;
    cache_addr    = '0;
    cache_load    = 1'b0;
    cache_edit    = 1'b0;
    cache_store   = 1'b0;
    cache_u_b_h_w = '0;
    cache_din     = '0;
    mem_cs_c      = 1'b0;
    mem_we_c      = 1'b0;
    mem_addr_c    = '0;
    mem_data_c    = '0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          if (req_c) begin
            stall         = 1'b1;
            cache_addr    = addr_rw;
            cache_load    = en_r;
            cache_edit    = en_w;
            cache_din     = data_w;
            cache_u_b_h_w = u_b_h_w;
          end
        end
        S_LOOKUP: begin
          // A write hit was already applied by the array on the previous edge.
          if (cache_hit) data_r = cache_dout;
          else           stall  = 1'b1;
        end
        S_PRE_BACK: begin
          // Address the victim word so the array returns it on the next edge.
          stall         = 1'b1;
          cache_addr    = back_addr;
          cache_u_b_h_w = WIDTH_WORD;
        end
        S_BACK: begin
          // Keep the array address steady so cache_dout holds until the ack.
          stall         = 1'b1;
          cache_addr    = back_addr;
          cache_u_b_h_w = WIDTH_WORD;
          mem_cs_c      = 1'b1;
          mem_we_c      = 1'b1;
          mem_addr_c    = back_addr;
          mem_data_c    = cache_dout;
        end
        S_FILL: begin
          stall      = 1'b1;
          mem_cs_c   = 1'b1;
          mem_addr_c = fill_addr;
          // Store keeps the LRU way unchanged, so all 4 words land in one way.
          if (mem.mem_ack_i) begin
            cache_store   = 1'b1;
            cache_addr    = fill_addr;
            cache_din     = mem.mem_data_i;
            cache_u_b_h_w = WIDTH_WORD;
          end
        end
        S_WAIT: begin
          // Replay the original request against the freshly filled line.
          stall         = 1'b1;
          cache_addr    = addr_rw;
          cache_load    = en_r;
          cache_edit    = en_w;
          cache_din     = data_w;
          cache_u_b_h_w = u_b_h_w;
        end
        default: begin
          stall = 1'b1;
        end
      endcase
    end
  end

endmodule
